mvau_fold_ctrl: RTL
===================

// Module: mvau_fold_ctrl
// PURPOSE
//  Sequencer in front of the MVAU compute datapath. Accepts the input activation stream
//  (SIMD words/beat), buffers one input vector, replays it once per neuron fold, and drives
//  weight-memory address and accumulator clear/last strobes. Sits between the input AXI-Stream
//  slave and the PE/SIMD array; the output stage back-pressures it through dp_hold.
// PARAMETERS
//  SIMD     2  input elements per beat
//  PE       2  parallel output neurons
//  MatrixW  8  weight matrix width (SF = MatrixW/SIMD synapse folds)
//  MatrixH  4  weight matrix height (NF = MatrixH/PE neuron folds)
//  TSrcI    4  bits per input element
//  WA_W     $clog2(SF*NF) (min 1) weight address width, derived, not overridable
// PORTS
//  aclk            in   1           clock, rising edge
//  aresetn         in   1           async reset, active low
//  s0_axis_tvalid  in   1           input beat valid
//  s0_axis_tready  out  1           input beat ready
//  s0_axis_tdata   in   SIMD*TSrcI  input beat
//  dp_hold         in   1           output stage full and not drained; freezes issue
//  dp_in_v         out  1           datapath operand valid (one issued beat)
//  dp_in_data      out  SIMD*TSrcI  datapath operand
//  wmem_addr       out  WA_W        weight word address = nf*SF + sf
//  acc_clr         out  1           first synapse fold of current neuron fold
//  acc_last        out  1           last synapse fold; datapath emits PE results
//  vec_done        out  1           pulse: full vector (all NF folds) issued
//  perf_busy_cnt   out  32          issue-cycle count (see CONFIGURATION)
//  perf_stall_cnt  out  32          dp_hold cycles with pending work (see CONFIGURATION)
// BEHAVIOUR
//  - States: FILL (nf==0, consuming stream), REPLAY (nf>0, reading vector buffer). Reset -> FILL.
//  - Counters sf in [0,SF-1], nf in [0,NF-1]; vector buffer buf[0:SF-1] of SIMD*TSrcI, no reset needed.
//  - s0_axis_tready = (state==FILL) & !dp_hold; combinational, no dependence on tvalid.
//  - Issue condition: FILL: tvalid&tready; REPLAY: !dp_hold. Only issue advances sf/nf.
//  - On issue (registered, latency 1): dp_in_v<=1; dp_in_data<=FILL ? tdata : buf[sf];
//    wmem_addr<=nf*SF+sf; acc_clr<=(sf==0); acc_last<=(sf==SF-1); FILL also writes buf[sf]<=tdata.
//  - No issue: dp_in_v<=0, acc_clr<=0, acc_last<=0, vec_done<=0; dp_in_data/wmem_addr hold.
//  - sf==SF-1 on issue: sf<=0; nf==NF-1 -> nf<=0, state FILL, vec_done<=1 next cycle;
//    else nf<=nf+1, state REPLAY. NF==1: never enters REPLAY, tready stays high under no hold.
//  - SF==1: acc_clr and acc_last both set on every issued beat.
//  - dp_hold asserted mid-fold: issue freezes at current sf/nf, no beat dropped or duplicated.
//  - Replayed data in REPLAY bit-identical to beats captured in FILL of same vector.
//  - Reset (async, any state): all outputs 0, sf=nf=0, state FILL; partial vector discarded.
//  - Steady state, no hold: one issue/cycle; SF*NF cycles per vector, of which SF accept input.
// CONFIGURATION
//  MVAU_CTRL_PERF_EN defined: perf_busy_cnt increments each issue cycle; perf_stall_cnt
//  increments each cycle dp_hold=1 while (state==REPLAY or s0_axis_tvalid=1); both 32-bit,
//  wrap at 2^32, cleared by reset only.
//  Not defined: both ports present, tied to 0, no counter flops.
// TESTING (SIMD=2, PE=2, MatrixW=8, MatrixH=4 -> SF=4, NF=2 unless stated)
//  1 tvalid=1 continuous, dp_hold=0, beats D0..D3 -> tready high 4 cycles then low 4; wmem_addr
//    0..7 on consecutive dp_in_v; acc_clr at addr 0,4; acc_last at 3,7; addr 4..7 carry D0..D3;
//    vec_done one cycle after addr 7.
//  2 tvalid toggling 1,0,1,0 -> issue only on handshake; addr sequence still 0..7, no gaps
//    in REPLAY, no duplicated beat.
//  3 dp_hold=1 for 3 cycles after addr 5 issued -> dp_in_v=0 3 cycles, wmem_addr stays 5,
//    resumes with addr 6 data D2.
//  4 aresetn=0 after addr 6 issued -> all outputs 0 immediately; next vector starts addr 0,
//    acc_clr=1, tready=1.
//  5 SIMD=8, MatrixW=8, MatrixH=2 (SF=1,NF=1) -> tready constantly 1, every beat addr 0,
//    acc_clr=acc_last=vec_done=1.
//  6 MVAU_CTRL_PERF_EN set, scenario 3 -> perf_busy_cnt=8, perf_stall_cnt=3; macro unset -> both 0.

Source files
------------

// File: rtl/mvau_fold_ctrl.sv
// mvau_fold_ctrl: issue sequencer in front of the MVAU PE/SIMD datapath.
//   Captures one input vector from the AXI-Stream slave (SF beats of SIMD
//   elements) while issuing it for neuron fold 0, then replays the buffered
//   vector for neuron folds 1..NF-1. Drives the weight-word address and the
//   accumulator clear/last strobes for every issued beat.
//
// Optional feature macro: MVAU_CTRL_PERF_EN
//   defined   : perf_busy_cnt / perf_stall_cnt are live 32-bit wrapping counters
//   undefined : both perf ports are tied to zero and no counter flops exist
//
// Ports
//   aclk, aresetn     clock (rising edge), asynchronous active-low reset
//   s0_axis_tvalid    input beat valid
//   s0_axis_tready    input beat ready (combinational: FILL state and no hold)
//   s0_axis_tdata     input beat, SIMD*TSrcI bits
//   dp_hold           output stage full; freezes issue
//   dp_in_v           datapath operand valid, one cycle per issued beat
//   dp_in_data        datapath operand
//   wmem_addr         weight word address, nf*SF + sf
//   acc_clr           first synapse fold of the current neuron fold
//   acc_last          last synapse fold of the current neuron fold
//   vec_done          pulse with the final beat of the final neuron fold
//   perf_busy_cnt     issue-cycle counter
//   perf_stall_cnt    hold-with-pending-work cycle counter
module mvau_fold_ctrl #(
  parameter int unsigned SIMD    = 2,
  parameter int unsigned PE      = 2,
  parameter int unsigned MatrixW = 8,
  parameter int unsigned MatrixH = 4,
  parameter int unsigned TSrcI   = 4,
  localparam int unsigned SF     = MatrixW / SIMD,
  localparam int unsigned NF     = MatrixH / PE,
  localparam int unsigned DW     = SIMD * TSrcI,
  localparam int unsigned WA_W   = (SF * NF > 1) ? $clog2(SF * NF) : 1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            s0_axis_tvalid,
  output logic            s0_axis_tready,
  input  logic [DW-1:0]   s0_axis_tdata,
  input  logic            dp_hold,
  output logic            dp_in_v,
  output logic [DW-1:0]   dp_in_data,
  output logic [WA_W-1:0] wmem_addr,
  output logic            acc_clr,
  output logic            acc_last,
  output logic            vec_done,
  output logic [31:0]     perf_busy_cnt,
  output logic [31:0]     perf_stall_cnt
);

  localparam int unsigned SF_W = (SF > 1) ? $clog2(SF) : 1;
  localparam int unsigned NF_W = (NF > 1) ? $clog2(NF) : 1;

  typedef enum logic {
    S_FILL   = 1'b0,
    S_REPLAY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SF_W-1:0]   sf_q, sf_d;
  logic [NF_W-1:0]   nf_q, nf_d;

  // One input vector; written only while filling, so it needs no reset.
  logic [DW-1:0]     vec_buf [SF];

  logic              issue_c;
  logic              sf_last_c;
  logic              nf_last_c;

  logic              dp_in_v_d;
  logic [DW-1:0]     dp_in_data_d;
  logic [WA_W-1:0]   wmem_addr_d;
  logic              acc_clr_d;
  logic              acc_last_d;
  logic              vec_done_d;

  // Ready depends only on state and hold, never on tvalid.
  assign s0_axis_tready = (state_q == S_FILL) && !dp_hold;

  assign sf_last_c = (sf_q == SF_W'(SF - 1));
  assign nf_last_c = (nf_q == NF_W'(NF - 1));

  // Next-state, fold counters and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    sf_d         = sf_q;
    nf_d         = nf_q;
    issue_c      = 1'b0;
    dp_in_v_d    = 1'b0;
    dp_in_data_d = dp_in_data;
    wmem_addr_d  = wmem_addr;
    acc_clr_d    = 1'b0;
    acc_last_d   = 1'b0;
    vec_done_d   = 1'b0;

    case (state_q)
      S_FILL:   issue_c = s0_axis_tvalid && !dp_hold;
      S_REPLAY: issue_c = !dp_hold;
      default:  issue_c = 1'b0;
    endcase

    if (issue_c) begin
      dp_in_v_d    = 1'b1;
      dp_in_data_d = (state_q == S_FILL) ? s0_axis_tdata : vec_buf[sf_q];
      wmem_addr_d  = WA_W'(nf_q) * WA_W'(SF) + WA_W'(sf_q);
      acc_clr_d    = (sf_q == '0);
      acc_last_d   = sf_last_c;

      if (sf_last_c) begin
        sf_d = '0;
        if (nf_last_c) begin
          nf_d       = '0;
          state_d    = S_FILL;
          vec_done_d = 1'b1;
        end else begin
          nf_d    = nf_q + NF_W'(1);
          state_d = S_REPLAY;
        end
      end else begin
        sf_d = sf_q + SF_W'(1);
      end
    end
  end

  // State, counters and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_FILL;
      sf_q       <= '0;
      nf_q       <= '0;
      dp_in_v    <= 1'b0;
      dp_in_data <= '0;
      wmem_addr  <= '0;
      acc_clr    <= 1'b0;
      acc_last   <= 1'b0;
      vec_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sf_q       <= sf_d;
      nf_q       <= nf_d;
      dp_in_v    <= dp_in_v_d;
      dp_in_data <= dp_in_data_d;
      wmem_addr  <= wmem_addr_d;
      acc_clr    <= acc_clr_d;
      acc_last   <= acc_last_d;
      vec_done   <= vec_done_d;
    end
  end

  // Capture each accepted beat for the replay folds.
  always_ff @(posedge aclk) begin
    if (issue_c && (state_q == S_FILL)) begin
      vec_buf[sf_q] <= s0_axis_tdata;
    end
  end

`ifdef MVAU_CTRL_PERF_EN
  logic [31:0] busy_q;
  logic [31:0] stall_q;

  // Stall counts only when work is actually waiting behind the hold.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      if (issue_c) begin
        busy_q <= busy_q + 32'd1;
      end
      if (dp_hold && ((state_q == S_REPLAY) || s0_axis_tvalid)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_busy_cnt  = busy_q;
  assign perf_stall_cnt = stall_q;
`else
  assign perf_busy_cnt  = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
